imem_loader: RTL

//  Write-side companion of the instruction memory: receives a program image as a byte stream
//  (from the UART/debug front end) and writes it word-by-word into the instruction memory

---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_word_packer.sv | 39 +++
 rtl/imem_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// ============================================================================
// Module      : imem_pkg
// Description : Shared loader state codes and instruction-memory constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_pkg;

    localparam int IMEM_DEPTH_DEFAULT = 49;
    localparam int BYTE_ADDR_SHIFT    = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_CHK   = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/imem_word_packer.sv
// ============================================================================
// Module      : imem_word_packer
// Description : Little-endian byte-to-word assembler; flags the completing byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  r_byte_cnt;
    logic [31:0] r_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= 2'd0;
            r_word     <= 32'd0;
        end else if (clear) begin
            r_byte_cnt <= 2'd0;
        end else if (byte_valid) begin
            r_word[{r_byte_cnt, 3'b000} +: 8] <= byte_data;
            r_byte_cnt                        <= r_byte_cnt + 2'd1;
        end
    end

    // Asserted during the cycle whose accepted byte completes the word.
    assign word_full = byte_valid && (r_byte_cnt == 2'd3);
    assign word      = r_word;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Byte-stream program loader writing words into instruction memory.
//               Optional trailer checksum when LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH_DEFAULT,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          core_hold,
    output logic          load_done,
    output logic          load_err
);

    localparam logic [15:0] c_depth = 16'(DEPTH);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e c_after_last = ST_CHK;
`else
    localparam loader_state_e c_after_last = ST_DONE;
`endif

    loader_state_e r_state;
    loader_state_e w_next;
    logic [15:0]   r_len;
    logic [15:0]   r_word_idx;
    logic [15:0]   w_len_full;
    logic          w_accept;
    logic          w_start;
    logic          w_pack_valid;
    logic          w_pack_full;
    logic [31:0]   w_pack_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    r_xor;
`endif

    assign w_accept     = in_valid && in_ready;
    assign w_start      = load_start &&
                          (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
    assign w_len_full   = {in_data, r_len[7:0]};
    assign w_pack_valid = w_accept && (r_state == ST_DATA);

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_start),
        .byte_valid (w_pack_valid),
        .byte_data  (in_data),
        .word       (w_pack_word),
        .word_full  (w_pack_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (load_start) w_next = ST_LEN0;
            end
            ST_LEN0: begin
                if (w_accept) w_next = ST_LEN1;
            end
            ST_LEN1: begin
                if (w_accept) begin
                    if (w_len_full > c_depth)       w_next = ST_ERR;
                    else if (w_len_full == 16'd0)   w_next = c_after_last;
                    else                            w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_pack_full) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (r_word_idx + 16'd1 == r_len) w_next = c_after_last;
                else                             w_next = ST_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (w_accept) w_next = (in_data == r_xor) ? ST_DONE : ST_ERR;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= 16'd0;
            r_word_idx <= 16'd0;
        end else if (w_start) begin
            r_len      <= 16'd0;
            r_word_idx <= 16'd0;
        end else begin
            if (w_accept && r_state == ST_LEN0) r_len[7:0]  <= in_data;
            if (w_accept && r_state == ST_LEN1) r_len[15:8] <= in_data;
            if (r_state == ST_WRITE)            r_word_idx  <= r_word_idx + 16'd1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Covers length and payload bytes; the trailer itself is compared, not folded in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xor <= 8'd0;
        end else if (w_start) begin
            r_xor <= 8'd0;
        end else if (w_accept &&
                     (r_state == ST_LEN0 || r_state == ST_LEN1 || r_state == ST_DATA)) begin
            r_xor <= r_xor ^ in_data;
        end
    end
`endif

    assign in_ready   = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                        (r_state == ST_DATA) || (r_state == ST_CHK);
    assign imem_we    = (r_state == ST_WRITE);
    assign imem_waddr = AW'(r_word_idx) << BYTE_ADDR_SHIFT;
    assign imem_wdata = w_pack_word;
    assign core_hold  = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                        (r_state == ST_DATA) || (r_state == ST_WRITE) ||
                        (r_state == ST_CHK);
    assign load_done  = (r_state == ST_DONE);
    assign load_err   = (r_state == ST_ERR);

endmodule

`default_nettype wire
